regbus_host: RTL and testbench
==============================

REGBUS_HOST -- requirements
Module: regbus_host

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, max cycles waiting for regack after regreq.
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rxdata  input  8  command byte stream.
REQ-005 SHALL have port rxvalid  input  1  rxdata valid.
REQ-006 SHALL have port rxready  output  1  byte accepted when rxvalid&&rxready.
REQ-007 SHALL have port txdata  output  8  response byte stream.
REQ-008 SHALL have port txvalid  output  1  txdata valid.
REQ-009 SHALL have port txready  input  1  byte consumed when txvalid&&txready.
REQ-010 SHALL have ports regreq output 1, regwr output 1, regaddr output 12, regwdata output 32: register-bus request, single-cycle regreq pulse.
REQ-011 SHALL have ports regack input 1, regerr input 1, regrdata input 32: responder completion pulse, error flag and read data, valid in regack cycle.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, ADDR, WDATA, REQ, WAIT, STATUS, RDATA.
REQ-014 IDLE: rxready=1; accepted byte is opcode; 0x00 read or 0x01 write -> ADDR; any other -> STATUS with status 0x03, no bus cycle.
REQ-015 ADDR: rxready=1; accept 2 bytes big-endian; regaddr = low 12 bits, upper 4 bits discarded; read -> REQ, write -> WDATA.
REQ-016 WDATA: rxready=1; accept 4 bytes big-endian into regwdata (first byte = bits 31:24) -> REQ.
REQ-017 rxready SHALL be 0 in REQ, WAIT, STATUS, RDATA.
REQ-018 REQ: assert regreq for exactly one cycle with regwr=1 for write, 0 for read -> WAIT; timeout counter cleared.
REQ-019 regaddr, regwr, regwdata SHALL be stable from REQ cycle until leaving WAIT.
REQ-020 WAIT: on regack: status = regerr ? 0x01 : 0x00; on read capture regrdata same cycle -> STATUS.
REQ-021 WAIT: counter increments each cycle without regack; when it reaches TIMEOUT, status 0x02 -> STATUS; regack in that same cycle takes precedence over timeout.
REQ-022 regack in any state other than WAIT SHALL be ignored (late acks after timeout discarded).
REQ-023 STATUS: txvalid=1, txdata=status; on txready: successful read (status 0x00, regwr=0) -> RDATA, else -> IDLE.
REQ-024 RDATA: send captured read data as 4 bytes big-endian, one per txvalid&&txready -> IDLE after 4th.
REQ-025 txdata SHALL hold stable while txvalid&&!txready; txvalid never deasserts without handshake.
REQ-026 Throughput: one byte per cycle on rx and tx when the peer is always ready; regreq asserted the cycle after last command byte accepted.

Reset
REQ-027 On rst: state IDLE; regreq=0, regwr=0, regaddr=0, regwdata=0, txvalid=0, txdata=0, busy=0, rxready=1 in the cycle after rst deasserts; counters and byte indices cleared.
REQ-028 rst mid-frame or in WAIT SHALL abandon the transaction without emitting a response; a subsequent stale regack is ignored per REQ-022.

Structure
REQ-029 Opcodes (READ=0x00, WRITE=0x01), status codes (OK=0x00, BUSERR=0x01, TIMEOUT=0x02, BADOP=0x03) and state encoding SHALL live in a shared package.
REQ-030 Single module; no sub-module required.

Verification
REQ-031 Write: bytes 01 00 0C DE AD BE EF, responder acks 3 cycles later, regerr=0 -> one regreq pulse, regwr=1, regaddr=0x00C, regwdata=0xDEADBEEF; tx 00.
REQ-032 Read: bytes 00 F0 04, responder acks with regrdata=0x00000400 -> regaddr=0x004; tx 00 00 00 04 00.
REQ-033 Bus error: read addr 0x010, regack with regerr=1 -> tx 01 only.
REQ-034 Timeout: TIMEOUT=8, read, no ack -> tx 02 after 8 cycles in WAIT; ack injected 5 cycles later ignored, next command behaves normally.
REQ-035 Bad op: byte 0x7F -> no regreq; tx 03; next byte treated as new opcode.
REQ-036 Backpressure and reset: txready toggled randomly during read response -> bytes intact and ordered; rst asserted in WAIT -> no tx, busy=0, IDLE.

Source files
------------

// File: rtl/regbus_host_pkg.sv
// Shared opcodes, status codes, FSM encoding and byte helper for regbus_host.
package regbus_host_pkg;

  // Command opcodes (first byte of a frame)
  localparam logic [7:0] OpRead  = 8'h00;
  localparam logic [7:0] OpWrite = 8'h01;

  // Response status codes (first byte of a response)
  localparam logic [7:0] StatusOk      = 8'h00;
  localparam logic [7:0] StatusBusErr  = 8'h01;
  localparam logic [7:0] StatusTimeout = 8'h02;
  localparam logic [7:0] StatusBadOp   = 8'h03;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StReq,
    StWait,
    StStatus,
    StRdata
  } state_e;

  // Big-endian byte select: idx 0 returns bits 31:24.
  function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/regbus_host.sv
// Byte-stream to register-bus bridge: decodes read/write command frames from rx,
// runs one register-bus transaction with timeout, and returns status (+ read data) on tx.
module regbus_host
  import regbus_host_pkg::*;
#(
  // Max cycles spent in WAIT without regack; must be >= 1.
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxdata,
  input  logic        rxvalid,
  output logic        rxready,
  output logic [7:0]  txdata,
  output logic        txvalid,
  input  logic        txready,
  output logic        regreq,
  output logic        regwr,
  output logic [11:0] regaddr,
  output logic [31:0] regwdata,
  input  logic        regack,
  input  logic        regerr,
  input  logic [31:0] regrdata,
  output logic        busy
);

  // Counter only has to reach TIMEOUT-1: the last WAIT cycle is the one where it equals that.
  localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            wr_q, wr_d;
  logic [11:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [7:0]      status_q, status_d;
  logic [1:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Bus request fields come straight from registers so they hold through REQ and WAIT.
  assign regwr    = wr_q;
  assign regaddr  = addr_q;
  assign regwdata = wdata_q;
  assign busy     = (state_q != StIdle);

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    rxready  = 1'b0;
    txvalid  = 1'b0;
    txdata   = 8'h00;
    regreq   = 1'b0;

    unique case (state_q)
      StIdle: begin
        rxready = 1'b1;
        if (rxvalid) begin
          idx_d = 2'd0;
          if (rxdata == OpRead || rxdata == OpWrite) begin
            wr_d    = (rxdata == OpWrite);
            state_d = StAddr;
          end else begin
            status_d = StatusBadOp;
            state_d  = StStatus;
          end
        end
      end

      StAddr: begin
        rxready = 1'b1;
        if (rxvalid) begin
          if (idx_q == 2'd0) begin
            // High address byte: only its low nibble is kept.
            addr_d = {rxdata[3:0], addr_q[7:0]};
            idx_d  = 2'd1;
          end else begin
            addr_d  = {addr_q[11:8], rxdata};
            idx_d   = 2'd0;
            state_d = wr_q ? StWdata : StReq;
          end
        end
      end

      StWdata: begin
        rxready = 1'b1;
        if (rxvalid) begin
          wdata_d = {wdata_q[23:0], rxdata};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = StReq;
          end
        end
      end

      StReq: begin
        regreq  = 1'b1;
        cnt_d   = '0;
        state_d = StWait;
      end

      StWait: begin
        // Ack wins over timeout when both land in the same cycle.
        if (regack) begin
          status_d = regerr ? StatusBusErr : StatusOk;
          if (!wr_q) begin
            rdata_d = regrdata;
          end
          state_d = StStatus;
        end else if (cnt_q == CntLast) begin
          status_d = StatusTimeout;
          state_d  = StStatus;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StStatus: begin
        txvalid = 1'b1;
        txdata  = status_q;
        if (txready) begin
          idx_d   = 2'd0;
          state_d = (status_q == StatusOk && !wr_q) ? StRdata : StIdle;
        end
      end

      StRdata: begin
        txvalid = 1'b1;
        txdata  = be_byte(rdata_q, idx_q);
        if (txready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Transaction datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      status_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_regbus_host.sv
// Self-checking bench for regbus_host: directed vector table, hand-written corner
// sequences (stale ack, reset in WAIT / mid-frame) and randomized frames vs a model.
module tb_regbus_host;
  import regbus_host_pkg::*;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        rst;
  logic [7:0]  rxdata;
  logic        rxvalid;
  logic        rxready;
  logic [7:0]  txdata;
  logic        txvalid;
  logic        txready;
  logic        regreq;
  logic        regwr;
  logic [11:0] regaddr;
  logic [31:0] regwdata;
  logic        regack;
  logic        regerr;
  logic [31:0] regrdata;
  logic        busy;

  regbus_host #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxdata   (rxdata),
    .rxvalid  (rxvalid),
    .rxready  (rxready),
    .txdata   (txdata),
    .txvalid  (txvalid),
    .txready  (txready),
    .regreq   (regreq),
    .regwr    (regwr),
    .regaddr  (regaddr),
    .regwdata (regwdata),
    .regack   (regack),
    .regerr   (regerr),
    .regrdata (regrdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int req_count = 0;
  logic [7:0] exp_q[$];

  // Count regreq cycles independently of the main thread
  always @(negedge clk) begin
    if (!rst && regreq) req_count <= req_count + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Offer one byte; returns in the cycle after it is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rxdata  = b;
    rxvalid = 1'b1;
    while (!rxready && n < 50) begin
      tick();
      n++;
    end
    if (!rxready) check("rx_accept_timeout", 32'(rxready), 32'd1);
    tick();
    rxvalid = 1'b0;
  endtask

  // Collect the response and compare with exp_q; checks hold-under-backpressure.
  task automatic recv_check(input bit rnd);
    logic [7:0] got[$];
    int         n = 0;
    bit         pend = 1'b0;
    logic [7:0] pend_data = 8'h00;
    while (got.size() < exp_q.size() && n < 300) begin
      txready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (pend) check("tx_hold", 32'({txvalid, txdata}), 32'({1'b1, pend_data}));
      if (txvalid && txready) got.push_back(txdata);
      pend      = txvalid && !txready;
      pend_data = txdata;
      tick();
      n++;
    end
    txready = 1'b0;
    check("tx_count", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check($sformatf("tx_byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
    end
    check("txvalid_after_resp", 32'(txvalid), 32'd0);
    check("busy_after_resp", 32'(busy), 32'd0);
    check("rxready_after_resp", 32'(rxready), 32'd1);
  endtask

  // Full frame: command bytes, responder behaviour (delay 0 = never ack), response check.
  task automatic run_txn(input logic [7:0] op, input logic [15:0] addr, input logic [31:0] wdata,
                         input int delay, input bit err, input logic [31:0] rdata,
                         input bit rnd, input int exp_req, input logic [11:0] exp_addr,
                         input bit exp_wr);
    int req0 = req_count;
    logic [7:0] bytes[$];
    bytes.push_back(op);
    if (exp_req != 0) begin
      bytes.push_back(addr[15:8]);
      bytes.push_back(addr[7:0]);
      if (exp_wr) for (int i = 3; i >= 0; i--) bytes.push_back(wdata[8*i +: 8]);
    end
    for (int i = 0; i < bytes.size(); i++) begin
      if (rnd && i > 0 && $urandom_range(0, 3) == 0) tick();
      send_byte(bytes[i]);
    end
    if (exp_req != 0) begin
      check("regreq_after_last_byte", 32'(regreq), 32'd1);
      check("regwr", 32'(regwr), 32'(exp_wr));
      check("regaddr", 32'(regaddr), 32'(exp_addr));
      if (exp_wr) check("regwdata", regwdata, wdata);
      if (delay >= 1 && delay <= int'(TO)) begin
        for (int k = 1; k <= delay; k++) begin
          tick();
          check("regreq_one_cycle", 32'(regreq), 32'd0);
          check("regaddr_stable", 32'(regaddr), 32'(exp_addr));
          check("regwr_stable", 32'(regwr), 32'(exp_wr));
          if (exp_wr) check("regwdata_stable", regwdata, wdata);
        end
        regack   = 1'b1;
        regerr   = err;
        regrdata = rdata;
        tick();
        regack   = 1'b0;
        regerr   = 1'b0;
        regrdata = $urandom;
      end else begin
        for (int k = 1; k <= int'(TO); k++) begin
          tick();
          check("no_tx_during_wait", 32'(txvalid), 32'd0);
          check("regaddr_stable_to", 32'(regaddr), 32'(exp_addr));
        end
        tick();
      end
    end
    check("txvalid_in_status", 32'(txvalid), 32'd1);
    check("rxready_in_status", 32'(rxready), 32'd0);
    check("regreq_count", 32'(req_count - req0), 32'(exp_req));
    recv_check(rnd);
  endtask

  // Reference model: response bytes and bus expectations from frame-level rules.
  task automatic model(input logic [7:0] op, input int delay, input bit err,
                       input logic [31:0] rdata, output int req, output bit wr);
    exp_q.delete();
    if (op != 8'h00 && op != 8'h01) begin
      req = 0;
      wr  = 1'b0;
      exp_q.push_back(8'h03);
    end else begin
      req = 1;
      wr  = (op == 8'h01);
      if (delay < 1 || delay > int'(TO)) exp_q.push_back(8'h02);
      else if (err) exp_q.push_back(8'h01);
      else begin
        exp_q.push_back(8'h00);
        if (!wr) for (int i = 3; i >= 0; i--) exp_q.push_back(rdata[8*i +: 8]);
      end
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          delay;
    bit          err;
    logic [31:0] rdata;
    int          exp_req;
    logic [11:0] exp_addr;
    bit          exp_wr;
    int          exp_n;
    logic [39:0] exp_bytes;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'h01, 16'h000C, 32'hDEADBEEF, 3, 1'b0, 32'h0,        1, 12'h00C, 1'b1, 1, 40'h00_0000_0000};
    vecs[1] = '{8'h00, 16'hF004, 32'h0,        3, 1'b0, 32'h00000400, 1, 12'h004, 1'b0, 5, 40'h00_0000_0400};
    vecs[2] = '{8'h00, 16'h0010, 32'h0,        2, 1'b1, 32'h12345678, 1, 12'h010, 1'b0, 1, 40'h01_0000_0000};
    vecs[3] = '{8'h00, 16'h0123, 32'h0,        0, 1'b0, 32'h0,        1, 12'h123, 1'b0, 1, 40'h02_0000_0000};
    vecs[4] = '{8'h7F, 16'h0,    32'h0,        0, 1'b0, 32'h0,        0, 12'h000, 1'b0, 1, 40'h03_0000_0000};
    vecs[5] = '{8'h00, 16'h0FFF, 32'h0,        8, 1'b0, 32'hA5A55A5A, 1, 12'hFFF, 1'b0, 5, 40'h00_A5A5_5A5A};
    vecs[6] = '{8'h01, 16'h1234, 32'h01020304, 1, 1'b1, 32'h0,        1, 12'h234, 1'b1, 1, 40'h01_0000_0000};
    vecs[7] = '{8'h01, 16'hABCD, 32'hCAFEF00D, 0, 1'b0, 32'h0,        1, 12'hBCD, 1'b1, 1, 40'h02_0000_0000};
    vecs[8] = '{8'h02, 16'h0,    32'h0,        0, 1'b0, 32'h0,        0, 12'h000, 1'b0, 1, 40'h03_0000_0000};
    vecs[9] = '{8'hFF, 16'h0,    32'h0,        0, 1'b0, 32'h0,        0, 12'h000, 1'b0, 1, 40'h03_0000_0000};

    rst = 1'b1; rxdata = 8'h00; rxvalid = 1'b0; txready = 1'b0;
    regack = 1'b0; regerr = 1'b0; regrdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rxready", 32'(rxready), 32'd1);
    check("rst_txvalid", 32'(txvalid), 32'd0);
    check("rst_txdata", 32'(txdata), 32'd0);
    check("rst_regreq", 32'(regreq), 32'd0);
    check("rst_regwr", 32'(regwr), 32'd0);
    check("rst_regaddr", 32'(regaddr), 32'd0);
    check("rst_regwdata", regwdata, 32'd0);

    // Directed vector table
    for (int v = 0; v < 10; v++) begin
      exp_q.delete();
      for (int i = 0; i < vecs[v].exp_n; i++) exp_q.push_back(vecs[v].exp_bytes[39-8*i -: 8]);
      run_txn(vecs[v].op, vecs[v].addr, vecs[v].wdata, vecs[v].delay, vecs[v].err,
              vecs[v].rdata, 1'b0, vecs[v].exp_req, vecs[v].exp_addr, vecs[v].exp_wr);
    end

    // Timeout, then a late ack during STATUS and another in IDLE must both be ignored
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h20);
    for (int k = 0; k <= int'(TO); k++) tick();
    check("to_status_valid", 32'(txvalid), 32'd1);
    for (int k = 0; k < 5; k++) tick();
    regack = 1'b1; regerr = 1'b1; regrdata = 32'hFFFFFFFF;
    tick();
    regack = 1'b0; regerr = 1'b0;
    check("late_ack_status_kept", 32'(txdata), 32'h02);
    exp_q.delete();
    exp_q.push_back(8'h02);
    recv_check(1'b0);
    regack = 1'b1; regrdata = 32'h55555555;
    tick();
    regack = 1'b0;
    check("late_ack_idle_busy", 32'(busy), 32'd0);
    check("late_ack_idle_txvalid", 32'(txvalid), 32'd0);
    exp_q.delete();
    exp_q.push_back(8'h00); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    run_txn(8'h00, 16'h0020, 32'h0, 4, 1'b0, 32'h11223344, 1'b0, 1, 12'h020, 1'b0);

    // Reset while in WAIT: no response, idle outputs, stale ack ignored
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h44);
    tick();
    tick();
    do_reset();
    check("rstwait_busy", 32'(busy), 32'd0);
    check("rstwait_rxready", 32'(rxready), 32'd1);
    check("rstwait_txvalid", 32'(txvalid), 32'd0);
    check("rstwait_regaddr", 32'(regaddr), 32'd0);
    regack = 1'b1; regrdata = 32'h99999999;
    tick();
    regack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("rstwait_no_tx", 32'(txvalid), 32'd0);
      check("rstwait_idle", 32'(busy), 32'd0);
      tick();
    end

    // Reset mid-frame, then a complete write must behave normally
    send_byte(8'h01);
    send_byte(8'h03);
    do_reset();
    check("rstmid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    exp_q.push_back(8'h00);
    run_txn(8'h01, 16'h0456, 32'h0BADF00D, 2, 1'b0, 32'h0, 1'b0, 1, 12'h456, 1'b1);

    // Randomized frames with tx backpressure and rx gaps
    for (int t = 0; t < 40; t++) begin
      logic [7:0]  op;
      logic [15:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      int          dly;
      bit          er;
      int          req;
      bit          wr;
      int          sel = int'($urandom_range(0, 19));
      if (sel < 9) op = 8'h00;
      else if (sel < 17) op = 8'h01;
      else op = 8'($urandom_range(2, 255));
      addr = 16'($urandom);
      wd   = $urandom;
      rd   = $urandom;
      dly  = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, TO));
      er   = ($urandom_range(0, 3) == 0);
      model(op, dly, er, rd, req, wr);
      run_txn(op, addr, wd, dly, er, rd, 1'b1, req, addr[11:0], wr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
